// File: rtl/gate_exerciser_if.sv
// gate_exerciser_if
// Groups the start/result handshake between the surrounding test logic and
// the gate exerciser.
//   start      test logic -> exerciser : launch a run (sampled only when idle)
//   gate_res   gate block -> exerciser : seven gate outputs
//                                        (0=AND 1=OR 2=NOT 3=NAND 4=NOR 5=XOR 6=XNOR)
//   a, b       exerciser -> gate block : registered gate inputs
//   busy/done  exerciser -> test logic : run in progress / one-cycle end pulse
//   pass, fail_mask, vec_fail, err_cnt : run status, held until next start
// Modports: master = test-logic side, slave = exerciser side.
interface gate_exerciser_if;
  logic       start;
  logic [6:0] gate_res;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] fail_mask;
  logic [3:0] vec_fail;
  logic [2:0] err_cnt;

  modport master (
    output start, gate_res,
    input  a, b, busy, done, pass, fail_mask, vec_fail, err_cnt
  );

  modport slave (
    input  start, gate_res,
    output a, b, busy, done, pass, fail_mask, vec_fail, err_cnt
  );
endinterface

// File: rtl/gate_exerciser.sv
// gate_exerciser
// Walks a two-input gate block through {a,b} = 00,01,10,11, waits
// SETTLE_CYCLES after each change, samples the seven gate outputs and
// compares them with the golden truth table. Reports a sticky per-gate
// failure mask, the failing vectors, a mismatch count and pass/done.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    gate_exerciser_if.slave (start, gate_res in; a, b, busy, done,
//          pass, fail_mask, vec_fail, err_cnt out)
module gate_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  gate_exerciser_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] fail_mask_q, fail_mask_d;
  logic [3:0] vec_fail_q, vec_fail_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic       pass_q, pass_d;
  logic [6:0] diff;

  function automatic logic [6:0] golden(input logic [1:0] v);
    case (v)
      2'd0:    golden = 7'h5C;
      2'd1:    golden = 7'h2E;
      2'd2:    golden = 7'h2A;
      default: golden = 7'h43;
    endcase
  endfunction

  assign diff = bus.gate_res ^ golden(vec_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      fail_mask_q <= '0;
      vec_fail_q  <= '0;
      err_cnt_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      fail_mask_q <= fail_mask_d;
      vec_fail_q  <= vec_fail_d;
      err_cnt_q   <= err_cnt_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    fail_mask_d = fail_mask_q;
    vec_fail_d  = vec_fail_q;
    err_cnt_d   = err_cnt_q;
    pass_d      = pass_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          vec_d       = '0;
          cnt_d       = '0;
          fail_mask_d = '0;
          vec_fail_d  = '0;
          err_cnt_d   = '0;
          pass_d      = 1'b0;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        fail_mask_d = fail_mask_q | diff;
        if (diff != '0) begin
          vec_fail_d[vec_q] = 1'b1;
          err_cnt_d         = err_cnt_q + 3'd1;
        end
        if (vec_q == 2'd3) begin
          // pass is registered on entry to DONE so it is valid alongside done.
          pass_d  = (fail_mask_d == '0);
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // {a,b} always equals the vector index, so the index register drives them.
  assign bus.a         = vec_q[1];
  assign bus.b         = vec_q[0];
  assign bus.busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_mask_q;
  assign bus.vec_fail  = vec_fail_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gate_exerciser.sv
module tb_gate_exerciser;

  localparam int unsigned S1   = 2;
  localparam int unsigned RUN1 = 4 * (S1 + 1);

  localparam logic [6:0] GOLD [4] = '{7'h5C, 7'h2E, 7'h2A, 7'h43};

  typedef struct {
    logic       pass;
    logic [6:0] mask;
    logic [3:0] vf;
    logic [2:0] ec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_exerciser_if if1 ();
  gate_exerciser_if if2 ();

  gate_exerciser #(.SETTLE_CYCLES(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  gate_exerciser #(.SETTLE_CYCLES(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural gate block: 0 good, 1 AND stuck-at-0, 2 XOR/XNOR swapped,
  // 3 random per-vector corruption.
  int               mode = 0;
  logic [3:0][6:0]  rnd  = '0;
  logic [6:0]       noise = '0;

  function automatic logic [6:0] gates(input logic a, input logic b);
    logic [6:0] g;
    g[0] = a & b;
    g[1] = a | b;
    g[2] = ~a;
    g[3] = ~(a & b);
    g[4] = ~(a | b);
    g[5] = a ^ b;
    g[6] = ~(a ^ b);
    return g;
  endfunction

  function automatic logic [6:0] block(input logic [1:0] v, input int m, input logic [6:0] r);
    logic [6:0] g;
    g = gates(v[1], v[0]);
    case (m)
      1: g[0] = 1'b0;
      2: g = {g[5], g[6], g[4:0]};
      3: g = g ^ r;
      default: ;
    endcase
    return g;
  endfunction

  function automatic exp_t expect_run(input int m, input logic [3:0][6:0] r);
    exp_t e;
    logic [6:0] d;
    e.mask = '0;
    e.vf   = '0;
    e.ec   = '0;
    for (int v = 0; v < 4; v++) begin
      d = block(2'(v), m, r[v]) ^ GOLD[v];
      e.mask |= d;
      if (d != 0) begin
        e.vf[v] = 1'b1;
        e.ec    = e.ec + 3'd1;
      end
    end
    e.pass = (e.mask == 0);
    return e;
  endfunction

  always @(negedge clk) noise = 7'($urandom);

  assign if1.gate_res = block({if1.a, if1.b}, mode, rnd[{if1.a, if1.b}]) ^ (if1.busy ? 7'h00 : noise);
  assign if2.gate_res = gates(if2.a, if2.b);

  // Reference run tracker: a start seen while idle launches a run lasting
  // RUN1 cycles plus the DONE cycle; the next start is sampled one cycle later.
  exp_t        sb [$];
  int unsigned cyc = 0;
  int unsigned launch = 0;
  bit          active = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      active = 1'b0;
    end else begin
      cyc++;
      if (active) begin
        if (cyc - launch == RUN1 + 1) active = 1'b0;
      end else if (if1.start) begin
        active = 1'b1;
        launch = cyc;
        sb.push_back(expect_run(mode, rnd));
      end
    end
  end

  // Monitor for dut1.
  exp_t        last;
  logic [1:0]  last_ab;
  exp_t        e;
  int unsigned k;
  int unsigned kv;

  always @(negedge clk) begin
    if (!rst_n) begin
      last    = '{pass: 1'b0, mask: 7'h0, vf: 4'h0, ec: 3'h0};
      last_ab = 2'b00;
      check("rst_ab",   {if1.a, if1.b}, 0);
      check("rst_busy", if1.busy, 0);
      check("rst_done", if1.done, 0);
    end else if (active) begin
      k  = cyc - launch;
      kv = k / (S1 + 1);
      if (kv > 3) kv = 3;
      check("ab_seq", {if1.a, if1.b}, int'(kv));
      check("busy_run", if1.busy, int'(k < RUN1));
      if (k == RUN1) begin
        check("done", if1.done, 1);
        if (sb.size() == 0) begin
          check("sb_pop", 0, 1);
        end else begin
          e = sb.pop_front();
          check("pass",      if1.pass,      e.pass);
          check("fail_mask", if1.fail_mask, e.mask);
          check("vec_fail",  if1.vec_fail,  e.vf);
          check("err_cnt",   if1.err_cnt,   e.ec);
          last    = e;
          last_ab = 2'b11;
        end
      end else begin
        check("done_early", if1.done, 0);
        check("pass_run",   if1.pass, 0);
      end
    end else begin
      check("idle_ab",   {if1.a, if1.b}, last_ab);
      check("idle_busy", if1.busy, 0);
      check("idle_done", if1.done, 0);
      check("hold_pass", if1.pass, last.pass);
      check("hold_mask", if1.fail_mask, last.mask);
      check("hold_vf",   if1.vec_fail, last.vf);
      check("hold_ec",   if1.err_cnt, last.ec);
    end
  end

  task automatic randomize_faults();
    for (int v = 0; v < 4; v++)
      rnd[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
  endtask

  // One run on dut1; extra_at injects a start pulse k cycles into the run,
  // noisy scatters random start pulses while the run is still busy.
  task automatic run(input int m, input int extra_at, input bit noisy);
    mode = m;
    @(negedge clk) if1.start = 1'b1;
    @(negedge clk) if1.start = 1'b0;
    for (int i = 1; i <= int'(RUN1) + 2; i++) begin
      @(negedge clk);
      if1.start = (i == extra_at) || (noisy && i <= 11 && $urandom_range(0, 2) == 0);
    end
    if1.start = 1'b0;
  endtask

  initial begin
    if1.start = 1'b0;
    if2.start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_pass", if1.pass, 0);
    check("rst_mask", if1.fail_mask, 0);
    check("rst_vf",   if1.vec_fail, 0);
    check("rst_ec",   if1.err_cnt, 0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run(0, 0, 1'b0);   // good block
    run(1, 0, 1'b0);   // AND stuck at 0
    run(2, 0, 1'b0);   // XOR/XNOR swapped
    run(0, 0, 1'b0);   // good again: status must clear
    run(0, 5, 1'b0);   // restart attempt mid-run is ignored

    for (int r = 0; r < 6; r++) begin
      randomize_faults();
      run(3, 0, 1'b1);
    end

    // start held high: back-to-back runs with one idle cycle between.
    randomize_faults();
    mode = 3;
    @(negedge clk) if1.start = 1'b1;
    repeat (3 * (RUN1 + 2)) @(negedge clk);
    if1.start = 1'b0;
    repeat (RUN1 + 4) @(negedge clk);

    // Faulty run then reset during vec2 settle.
    mode = 2;
    @(negedge clk) if1.start = 1'b1;
    @(negedge clk) if1.start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ab",   {if1.a, if1.b}, 0);
    check("arst_busy", if1.busy, 0);
    check("arst_done", if1.done, 0);
    check("arst_pass", if1.pass, 0);
    check("arst_mask", if1.fail_mask, 0);
    check("arst_vf",   if1.vec_fail, 0);
    check("arst_ec",   if1.err_cnt, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run(0, 0, 1'b0);

    // SETTLE_CYCLES=1 build.
    @(negedge clk) if2.start = 1'b1;
    @(negedge clk) if2.start = 1'b0;
    for (int kk = 0; kk < 10; kk++) begin
      check("s1_ab",   {if2.a, if2.b}, (kk / 2 > 3) ? 3 : kk / 2);
      check("s1_busy", if2.busy, int'(kk < 8));
      check("s1_done", if2.done, int'(kk == 8));
      if (kk == 8) begin
        check("s1_pass", if2.pass, 1);
        check("s1_mask", if2.fail_mask, 0);
        check("s1_vf",   if2.vec_fail, 0);
        check("s1_ec",   if2.err_cnt, 0);
      end
      @(negedge clk);
    end

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
